// File: rtl/ibex_pkg.sv
// Shared ibex types: interrupt bundle, exception causes, and the interrupt
// controller's state encoding and fast-irq cause helper.
package ibex_pkg;

  localparam int unsigned NUM_FAST_IRQS = 15;
  localparam int unsigned IRQ_W         = 18;

  typedef struct packed {
    logic                     irq_software;
    logic                     irq_timer;
    logic                     irq_external;
    logic [NUM_FAST_IRQS-1:0] irq_fast;
  } irqs_t;

  typedef enum logic [5:0] {
    EXC_CAUSE_INSN_ADDR_MISA     = {1'b0, 5'd00},
    EXC_CAUSE_INSTR_ACCESS_FAULT = {1'b0, 5'd01},
    EXC_CAUSE_ILLEGAL_INSN       = {1'b0, 5'd02},
    EXC_CAUSE_BREAKPOINT         = {1'b0, 5'd03},
    EXC_CAUSE_LOAD_ACCESS_FAULT  = {1'b0, 5'd05},
    EXC_CAUSE_STORE_ACCESS_FAULT = {1'b0, 5'd07},
    EXC_CAUSE_ECALL_UMODE        = {1'b0, 5'd08},
    EXC_CAUSE_ECALL_MMODE        = {1'b0, 5'd11},
    EXC_CAUSE_IRQ_SOFTWARE_M     = {1'b1, 5'd03},
    EXC_CAUSE_IRQ_TIMER_M        = {1'b1, 5'd07},
    EXC_CAUSE_IRQ_EXTERNAL_M     = {1'b1, 5'd11},
    EXC_CAUSE_IRQ_FAST_0         = {1'b1, 5'd16},
    EXC_CAUSE_IRQ_FAST_1         = {1'b1, 5'd17},
    EXC_CAUSE_IRQ_FAST_2         = {1'b1, 5'd18},
    EXC_CAUSE_IRQ_FAST_3         = {1'b1, 5'd19},
    EXC_CAUSE_IRQ_FAST_4         = {1'b1, 5'd20},
    EXC_CAUSE_IRQ_FAST_5         = {1'b1, 5'd21},
    EXC_CAUSE_IRQ_FAST_6         = {1'b1, 5'd22},
    EXC_CAUSE_IRQ_FAST_7         = {1'b1, 5'd23},
    EXC_CAUSE_IRQ_FAST_8         = {1'b1, 5'd24},
    EXC_CAUSE_IRQ_FAST_9         = {1'b1, 5'd25},
    EXC_CAUSE_IRQ_FAST_10        = {1'b1, 5'd26},
    EXC_CAUSE_IRQ_FAST_11        = {1'b1, 5'd27},
    EXC_CAUSE_IRQ_FAST_12        = {1'b1, 5'd28},
    EXC_CAUSE_IRQ_FAST_13        = {1'b1, 5'd29},
    EXC_CAUSE_IRQ_FAST_14        = {1'b1, 5'd30},
    EXC_CAUSE_IRQ_NM             = {1'b1, 5'd31}
  } exc_cause_e;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_NMI  = 2'd2
  } irq_state_e;

  function automatic exc_cause_e irq_fast_cause(input logic [3:0] i);
    return exc_cause_e'({1'b1, 5'd16 + 5'(i)});
  endfunction

endpackage

// File: rtl/ibex_irq_sync.sv
// Register stage for raw interrupt pins: one flop, or a two-flop
// synchroniser when the pins are asynchronous to the core clock.
module ibex_irq_sync #(
  parameter int unsigned Width    = 1,
  parameter bit          TwoStage = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage0 <= '0;
    else     stage0 <= d;
  end

  if (TwoStage) begin : g_two
    logic [Width-1:0] stage1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) stage1 <= '0;
      else     stage1 <= stage0;
    end

    assign q = stage1;
  end else begin : g_one
    assign q = stage0;
  end

endmodule

// File: rtl/ibex_irq_ctrl.sv
// Interrupt request controller: registers irq pins into mip, masks and
// prioritises pending causes, and hands one at a time to the controller.
module ibex_irq_ctrl
  import ibex_pkg::*;
#(
  parameter bit SyncInputs = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  input  logic [14:0] irq_fast_i,
  input  logic        irq_nm_i,
  input  logic        csr_mstatus_mie_i,
  input  irqs_t       csr_mie_i,
  input  logic        debug_mode_i,
  input  logic        irq_ack_i,
  input  logic        mret_i,
  output irqs_t       mip_o,
  output logic        irq_req_o,
  output exc_cause_e  irq_cause_o,
  output logic        nmi_mode_o
);

  localparam int unsigned IrqInW = IRQ_W + 1;

  // Highest priority first: NMI, fast[0..14], external, software, timer.
  function automatic exc_cause_e pick_cause(input logic nmi, input irqs_t irqs);
    exc_cause_e c;
    c = EXC_CAUSE_IRQ_TIMER_M;
    if (irqs.irq_software) c = EXC_CAUSE_IRQ_SOFTWARE_M;
    if (irqs.irq_external) c = EXC_CAUSE_IRQ_EXTERNAL_M;
    for (int i = int'(NUM_FAST_IRQS) - 1; i >= 0; i--) begin
      if (irqs.irq_fast[i]) c = irq_fast_cause(4'(i));
    end
    if (nmi) c = EXC_CAUSE_IRQ_NM;
    return c;
  endfunction

  // True while the maskable source behind cause c is still a candidate.
  function automatic logic cause_pending(input exc_cause_e c, input irqs_t irqs);
    logic hit;
    hit = 1'b0;
    case (c)
      EXC_CAUSE_IRQ_SOFTWARE_M: hit = irqs.irq_software;
      EXC_CAUSE_IRQ_TIMER_M:    hit = irqs.irq_timer;
      EXC_CAUSE_IRQ_EXTERNAL_M: hit = irqs.irq_external;
      default:                  hit = 1'b0;
    endcase
    for (int i = 0; i < int'(NUM_FAST_IRQS); i++) begin
      if (c == irq_fast_cause(4'(i))) hit = irqs.irq_fast[i];
    end
    return hit;
  endfunction

  logic [IrqInW-1:0] irq_raw;
  logic [IrqInW-1:0] irq_sync;
  logic              nmi_q;
  logic              nmi_q_d;
  logic              nmi_pend_q;
  logic              nmi_pend_d;
  logic              maskable_en;
  logic              nmi_en;
  logic              nmi_cand;
  irqs_t             irq_cand;
  logic              any_cand;
  logic              cause_is_nm;
  logic              nm_ack;
  exc_cause_e        win_cause;
  irq_state_e        state_q;
  irq_state_e        state_d;
  exc_cause_e        cause_q;
  exc_cause_e        cause_d;
  logic              irq_req_q;
  logic              nmi_mode_q;

  assign irq_raw = {irq_nm_i, irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};

  ibex_irq_sync #(
    .Width    (IrqInW),
    .TwoStage (SyncInputs)
  ) u_irq_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (irq_raw),
    .q   (irq_sync)
  );

  assign mip_o = irqs_t'(irq_sync[IRQ_W-1:0]);
  assign nmi_q = irq_sync[IrqInW-1];

  assign maskable_en = csr_mstatus_mie_i & ~debug_mode_i & ~nmi_mode_q;
  assign nmi_en      = ~debug_mode_i & ~nmi_mode_q;
  assign nmi_cand    = nmi_pend_q & nmi_en;
  assign irq_cand    = irqs_t'(mip_o & csr_mie_i & {IRQ_W{maskable_en}});
  assign any_cand    = nmi_cand | (|irq_cand);
  assign win_cause   = pick_cause(nmi_cand, irq_cand);
  assign cause_is_nm = (cause_q == EXC_CAUSE_IRQ_NM);
  assign nm_ack      = (state_q == IRQ_REQ) & irq_ack_i & cause_is_nm;

  // A new edge wins over a simultaneous ack of the previous one.
  assign nmi_pend_d = (nmi_q & ~nmi_q_d) | (nmi_pend_q & ~nm_ack);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nmi_q_d    <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_q_d    <= nmi_q;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IRQ_IDLE;
      cause_q    <= EXC_CAUSE_INSN_ADDR_MISA;
      irq_req_q  <= 1'b0;
      nmi_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      irq_req_q  <= (state_d == IRQ_REQ);
      nmi_mode_q <= (state_d == IRQ_NMI);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IRQ_IDLE: begin
        if (any_cand) begin
          state_d = IRQ_REQ;
          cause_d = win_cause;
        end
      end
      IRQ_REQ: begin
        if (irq_ack_i) begin
          state_d = cause_is_nm ? IRQ_NMI : IRQ_IDLE;
        end else if (nmi_cand && !cause_is_nm) begin
          cause_d = EXC_CAUSE_IRQ_NM;
        end else if (!cause_is_nm && !cause_pending(cause_q, irq_cand)) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_NMI: begin
        if (mret_i) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  assign irq_req_o   = irq_req_q;
  assign irq_cause_o = cause_q;
  assign nmi_mode_o  = nmi_mode_q;

endmodule

// File: doc/ibex_irq_ctrl.md
# ibex_irq_ctrl

Interrupt request controller between the raw core interrupt pins and the ibex controller/CSR file. It synchronises and registers the level interrupt inputs into the mip view and edge-detects the non-maskable interrupt. It applies mie/mstatus.MIE/debug/NMI-mode masking, selects the highest-priority pending cause, and presents it to the controller over a req/ack handshake. It also tracks NMI-handler mode until the matching mret.

## Interface
- `SyncInputs`, default 1: 1 = two-flop synchroniser on every irq input; 0 = single register stage only.
- `clk_i`  in  1  core clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `irq_software_i`  in  1  machine software irq, level
- `irq_timer_i`  in  1  machine timer irq, level
- `irq_external_i`  in  1  machine external irq, level
- `irq_fast_i`  in  15  fast irqs, level
- `irq_nm_i`  in  1  non-maskable irq; rising edge is significant
- `csr_mstatus_mie_i`  in  1  global machine interrupt enable
- `csr_mie_i`  in  18  irqs_t-packed enable mask
- `debug_mode_i`  in  1  core in debug mode; all interrupts blocked
- `irq_ack_i`  in  1  controller has taken the currently requested interrupt
- `mret_i`  in  1  mret retiring; ends NMI mode
- `mip_o`  out  18  irqs_t-packed registered pending view
- `irq_req_o`  out  1  interrupt request to controller
- `irq_cause_o`  out  6  exc_cause_e of the requested interrupt
- `nmi_mode_o`  out  1  NMI handler executing

## Operation
- Input path:
  - Each level input passes through the sync stage (SyncInputs=1: 2 flops; 0: 1 flop).
  - The last flop of each maskable input forms `mip_o`.
  - The NMI's last flop is `nmi_q`; `nmi_q_d` is one further delay of it.
- NMI pending:
  - `nmi_pend` is set when `nmi_q & ~nmi_q_d`.
  - It is cleared when `irq_ack_i` arrives with cause EXC_CAUSE_IRQ_NM.
  - A set and a clear in the same cycle leave it set.
- Enables:
  - `maskable_en = csr_mstatus_mie_i & ~debug_mode_i & ~nmi_mode_o`.
  - `nmi_en = ~debug_mode_i & ~nmi_mode_o`.
- Candidates:
  - `nmi_pend & nmi_en`.
  - `mip_o & csr_mie_i & {18{maskable_en}}`.
- Priority, highest first: NMI ({1,31}); fast[0]..fast[14] ({1,16+i}); external ({1,11}); software ({1,3}); timer ({1,7}).
- FSM states, registered: IDLE, REQ, NMI.
  - IDLE: if any candidate exists, latch the winning cause into `cause_q` and go to REQ.
  - REQ: `irq_req_o=1` and `irq_cause_o=cause_q`. The cause is held stable except as listed below.
  - REQ, `irq_ack_i`: go to NMI if `cause_q` is NM, otherwise IDLE. There is no re-request in the ack cycle.
  - REQ, no ack, NMI candidate present while `cause_q` is not NM: `cause_q` becomes NM next cycle (NMI preemption).
  - REQ, no ack, no candidate matches `cause_q` (level withdrawn or masked): drop to IDLE next cycle. An NM cause is never withdrawn.
  - NMI: `nmi_mode_o=1`, so no requests of any kind are made. On `mret_i`, go to IDLE.
  - `mret_i` outside the NMI state has no effect.
- `irq_ack_i` while not in REQ is ignored.

## Timing
- Reset values:
  - `mip_o`=0, `irq_req_o`=0, `irq_cause_o`=6'h00, `nmi_mode_o`=0.
  - FSM in IDLE; all sync flops, `nmi_q_d` and `nmi_pend` are 0.
- Latency, input high before clock edge k (SyncInputs=0): `mip_o` high after edge k; `irq_req_o` high after edge k+1.
- SyncInputs=1 adds one cycle to both of the above.
- NMI edge to `irq_req_o`: one cycle later than a level irq of the same SyncInputs (`nmi_pend` register).
- Ack: `irq_req_o` deasserts the cycle after the edge that samples `irq_ack_i`. `nmi_mode_o` asserts on that same edge for NM.
- Reset mid-operation (asserted in REQ or NMI): immediate return to reset values, asynchronously. A pending NMI edge is lost.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Package additions to ibex_pkg:
  - `irq_state_e` (IRQ_IDLE, IRQ_REQ, IRQ_NMI).
  - Function `irq_fast_cause(i)` returning {1'b1, 5'd16+i}.
  - Existing `irqs_t` and `exc_cause_e` are reused.
- Sub-module `ibex_irq_sync`: parameterised-width synchroniser (1 or 2 stages, async active-high reset), instantiated once for the 19 input bits.
- Priority select: combinational function inside the block.

## Test plan
- Basic request:
  - Stimulus: SyncInputs=0; `csr_mie_i` timer bit set, `csr_mstatus_mie_i`=1, `irq_timer_i`=1.
  - Required: `irq_req_o`=1 with cause 6'h27 two edges later.
  - Stimulus: ack one cycle later.
  - Required: `irq_req_o`=0 next cycle.
- Priority:
  - Stimulus: software, external, fast[3] and fast[9] raised together, all enabled.
  - Required: cause 6'h33 (fast[3]).
  - Stimulus: ack, drop fast[3].
  - Required: cause 6'h39 (fast[9]).
- Withdrawal and masking:
  - Stimulus: external requested, then `irq_external_i` dropped before ack.
  - Required: `irq_req_o` falls one cycle after `mip_o` bit 15 clears; state returns to IDLE.
  - Stimulus: repeat with `csr_mstatus_mie_i`=0 from the start.
  - Required: no request ever.
- NMI preemption and mode:
  - Stimulus: timer in REQ, then `irq_nm_i` rising edge.
  - Required: cause changes to 6'h3F without `irq_req_o` dropping.
  - Stimulus: ack.
  - Required: `nmi_mode_o`=1; a second NMI edge and the held timer produce no request.
  - Stimulus: `mret_i`.
  - Required: second NMI requested (6'h3F).
- Debug and reset:
  - Stimulus: `debug_mode_i`=1 with NMI edge and external pending.
  - Required: no request while debug is high; NMI requested after `debug_mode_i` falls.
  - Stimulus: `rst_i` pulsed while in REQ.
  - Required: all outputs 0 during reset, no request afterwards with inputs low.
